// File: rtl/seq_det_tdm_sched.sv
// Shared serial sequence detector: a round-robin arbiter feeds one engine that keeps
// a per-channel bit history, so overlapping matches on every channel are reported.
module seq_det_tdm_sched #(
    parameter int                NCH     = 4,
    parameter int                MAXLEN  = 8,
    parameter int                CHW     = $clog2(NCH),
    parameter logic [MAXLEN-1:0] PAT_RST = 8'b0001_0010,
    parameter int                LEN_RST = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    ch_valid,
    input  logic [NCH-1:0]    ch_bit,
    output logic [NCH-1:0]    ch_ready,
    input  logic              cfg_we,
    input  logic [MAXLEN-1:0] cfg_pattern,
    input  logic [3:0]        cfg_len,
    input  logic [NCH-1:0]    cfg_ch_en,
    output logic              det_valid,
    output logic [CHW-1:0]    det_ch,
    input  logic              det_ready
);

    localparam int FW = $clog2(MAXLEN + 1);

    logic [MAXLEN-1:0] hist_q [NCH];
    logic [FW-1:0]     fill_q [NCH];
    logic [MAXLEN-1:0] pattern_q;
    logic [FW-1:0]     len_q;
    logic [NCH-1:0]    ch_en_q;
    logic [CHW-1:0]    rr_ptr_q;
    logic              det_valid_q;
    logic [CHW-1:0]    det_ch_q;

    logic              stall_s;
    logic [NCH-1:0]    eligible_s;
    logic              grant_any_s;
    logic [CHW-1:0]    grant_s;
    logic [CHW-1:0]    idx_s;
    logic [MAXLEN-1:0] new_hist_s;
    logic [FW-1:0]     new_fill_s;
    logic [MAXLEN-1:0] mask_s;
    logic              match_s;
    logic [FW-1:0]     len_d;

    // Round-robin grant: first eligible channel at or after rr_ptr, wrapping.
    always_comb begin
        stall_s     = cfg_we | (det_valid_q & ~det_ready);
        eligible_s  = ch_valid & ch_en_q;
        grant_any_s = 1'b0;
        grant_s     = '0;
        idx_s       = '0;
        for (int i = 0; i < NCH; i++) begin
            idx_s       = rr_ptr_q + CHW'(i);
            grant_s     = (!grant_any_s && eligible_s[idx_s]) ? idx_s : grant_s;
            grant_any_s = grant_any_s | eligible_s[idx_s];
        end
        grant_any_s = grant_any_s & ~stall_s & ~rst;
        ch_ready    = grant_any_s ? ({{(NCH-1){1'b0}}, 1'b1} << grant_s) : '0;
    end

    // Engine: shift the granted bit into its history and compare the low len bits.
    always_comb begin
        new_hist_s = {hist_q[grant_s][MAXLEN-2:0], ch_bit[grant_s]};
        new_fill_s = (fill_q[grant_s] == FW'(MAXLEN)) ? fill_q[grant_s]
                                                     : fill_q[grant_s] + FW'(1);
        mask_s = '0;
        for (int i = 0; i < MAXLEN; i++) begin
            mask_s[i] = (FW'(i) < len_q);
        end
        // A zero length would trivially match everything, so it means "detection off".
        match_s = grant_any_s && (len_q != '0) &&
                  (((new_hist_s ^ pattern_q) & mask_s) == '0) &&
                  (new_fill_s >= len_q);
        len_d = (int'(cfg_len) > MAXLEN) ? FW'(MAXLEN) : FW'(cfg_len);
    end

    // State update: configuration, per-channel history and the detection output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                hist_q[c] <= '0;
                fill_q[c] <= '0;
            end
            pattern_q   <= PAT_RST;
            len_q       <= FW'(LEN_RST);
            ch_en_q     <= '1;
            rr_ptr_q    <= '0;
            det_valid_q <= 1'b0;
            det_ch_q    <= '0;
        end else begin
            if (cfg_we) begin
                pattern_q <= cfg_pattern;
                len_q     <= len_d;
                ch_en_q   <= cfg_ch_en;
                for (int c = 0; c < NCH; c++) begin
                    hist_q[c] <= '0;
                    fill_q[c] <= '0;
                end
            end else if (grant_any_s) begin
                hist_q[grant_s] <= new_hist_s;
                fill_q[grant_s] <= new_fill_s;
                rr_ptr_q        <= grant_s + CHW'(1);
            end else begin
                rr_ptr_q <= rr_ptr_q;
            end

            if (match_s) begin
                det_valid_q <= 1'b1;
                det_ch_q    <= grant_s;
            end else if (det_valid_q && det_ready) begin
                det_valid_q <= 1'b0;
            end else begin
                det_valid_q <= det_valid_q;
            end
        end
    end

    assign det_valid = det_valid_q;
    assign det_ch    = det_ch_q;

endmodule

// File: tb/tb_seq_det_tdm_sched.sv
// Bench for seq_det_tdm_sched: directed scenarios plus random traffic, all compared
// against a queue-based model of channel bit streams.
module tb_seq_det_tdm_sched;

    localparam int NCH    = 4;
    localparam int MAXLEN = 8;
    localparam int CHW    = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    ch_valid;
    logic [NCH-1:0]    ch_bit;
    logic [NCH-1:0]    ch_ready;
    logic              cfg_we;
    logic [MAXLEN-1:0] cfg_pattern;
    logic [3:0]        cfg_len;
    logic [NCH-1:0]    cfg_ch_en;
    logic              det_valid;
    logic [CHW-1:0]    det_ch;
    logic              det_ready;

    int checks = 0;
    int errors = 0;

    seq_det_tdm_sched #(.NCH(NCH), .MAXLEN(MAXLEN)) dut (
        .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_bit(ch_bit), .ch_ready(ch_ready),
        .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_ch_en(cfg_ch_en),
        .det_valid(det_valid), .det_ch(det_ch), .det_ready(det_ready)
    );

    always #5 clk = ~clk;

    // Reference model: each channel is the list of its accepted bits (oldest first).
    int             m_ptr;
    logic [NCH-1:0] m_en;
    bit             m_pat [MAXLEN];
    int             m_len;
    bit             m_hist [NCH][$];
    bit             m_dv;
    int             m_dch;
    logic [NCH-1:0] e_ready;
    bit             e_dv;
    int             e_dch;
    bit             e_grant;
    int             e_g;

    task automatic model_reset();
        logic [MAXLEN-1:0] p;
        p = 8'b0001_0010;
        m_ptr = 0;
        m_en  = '1;
        m_len = 5;
        for (int k = 0; k < MAXLEN; k++) m_pat[k] = p[k];
        for (int c = 0; c < NCH; c++) m_hist[c].delete();
        m_dv  = 1'b0;
        m_dch = 0;
    endtask

    task automatic model_eval();
        bit stall;
        int c;
        stall   = cfg_we || (m_dv && !det_ready);
        e_grant = 1'b0;
        e_g     = 0;
        if (!stall) begin
            for (int k = 0; k < NCH; k++) begin
                c = (m_ptr + k) % NCH;
                if (!e_grant && ch_valid[c] && m_en[c]) begin
                    e_grant = 1'b1;
                    e_g     = c;
                end
            end
        end
        e_ready = e_grant ? (NCH'(1) << e_g) : '0;
        e_dv    = m_dv;
        e_dch   = m_dch;
    endtask

    task automatic model_commit();
        bit hit;
        int sz;
        hit = 1'b0;
        if (cfg_we) begin
            m_en  = cfg_ch_en;
            m_len = (int'(cfg_len) > MAXLEN) ? MAXLEN : int'(cfg_len);
            for (int k = 0; k < MAXLEN; k++) m_pat[k] = cfg_pattern[k];
            for (int c = 0; c < NCH; c++) m_hist[c].delete();
        end else if (e_grant) begin
            m_hist[e_g].push_back(ch_bit[e_g]);
            if (m_hist[e_g].size() > MAXLEN) void'(m_hist[e_g].pop_front());
            m_ptr = (e_g + 1) % NCH;
            sz    = m_hist[e_g].size();
            hit   = (m_len > 0) && (sz >= m_len);
            if (hit) begin
                for (int k = 0; k < m_len; k++)
                    if (m_hist[e_g][sz-1-k] != m_pat[k]) hit = 1'b0;
            end
        end
        if (hit) begin
            m_dv  = 1'b1;
            m_dch = e_g;
        end else if (m_dv && det_ready) begin
            m_dv = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        ch_valid = '0; ch_bit = '0; cfg_we = 1'b0; cfg_pattern = '0;
        cfg_len = '0; cfg_ch_en = '0; det_ready = 1'b1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic do_cfg(input logic [MAXLEN-1:0] pat, input logic [3:0] len,
                          input logic [NCH-1:0] en);
        cfg_we = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_ch_en = en; ch_valid = '0;
        model_eval(); @(negedge clk);
        model_commit(); @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        ch_valid = '1;
        rst = 1'b1;
        #1;
        checks++; if (ch_ready !== 4'b0000) begin errors++; $display("FAIL reset ch_ready: got %b exp 0000", ch_ready); end
        @(posedge clk); #1;
        checks++; if (det_valid !== 1'b0) begin errors++; $display("FAIL reset det_valid: got %b exp 0", det_valid); end
        checks++; if (det_ch !== 2'd0) begin errors++; $display("FAIL reset det_ch: got %0d exp 0", det_ch); end
        rst = 1'b0;
        model_reset();
        ch_valid = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_overlap();
        bit seq [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            ch_valid = '0; ch_bit = '0;
            if (i < 8) begin ch_valid = 4'b0001; ch_bit[0] = seq[i]; end
            model_eval(); @(negedge clk);
            checks++; if (ch_ready !== e_ready) begin errors++; $display("FAIL overlap ch_ready c%0d: got %b exp %b", i, ch_ready, e_ready); end
            checks++; if (det_valid !== ((i == 5) || (i == 8))) begin errors++; $display("FAIL overlap det_valid c%0d: got %b exp %b", i, det_valid, ((i == 5) || (i == 8))); end
            checks++; if (det_valid !== e_dv) begin errors++; $display("FAIL overlap model det_valid c%0d: got %b exp %b", i, det_valid, e_dv); end
            if (e_dv) begin checks++; if (det_ch !== 2'd0) begin errors++; $display("FAIL overlap det_ch c%0d: got %0d exp 0", i, det_ch); end end
            model_commit(); @(posedge clk); #1;
        end
    endtask

    task automatic test_round_robin();
        logic [NCH-1:0] after_dis [6] = '{4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000};
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            ch_valid = '1; ch_bit = '0;
            model_eval(); @(negedge clk);
            checks++; if (ch_ready !== (NCH'(1) << (i % NCH))) begin errors++; $display("FAIL rr ch_ready c%0d: got %b exp %b", i, ch_ready, NCH'(1) << (i % NCH)); end
            model_commit(); @(posedge clk); #1;
        end
        do_cfg(8'b0001_0010, 4'd5, 4'b1101);
        for (int i = 0; i < 6; i++) begin
            ch_valid = '1; ch_bit = '0;
            model_eval(); @(negedge clk);
            checks++; if (ch_ready !== after_dis[i]) begin errors++; $display("FAIL rr_dis ch_ready c%0d: got %b exp %b", i, ch_ready, after_dis[i]); end
            checks++; if (ch_ready !== e_ready) begin errors++; $display("FAIL rr_dis model ch_ready c%0d: got %b exp %b", i, ch_ready, e_ready); end
            model_commit(); @(posedge clk); #1;
        end
    endtask

    task automatic test_cfg_pattern();
        bit pre [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        bit seq [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            ch_valid = 4'b0100; ch_bit = '0; ch_bit[2] = pre[i];
            model_eval(); @(negedge clk); model_commit(); @(posedge clk); #1;
        end
        do_cfg(8'b0001_1011, 4'd5, 4'b1111);
        for (int i = 0; i < 10; i++) begin
            ch_valid = '0; ch_bit = '0;
            if (i < 8) begin ch_valid = 4'b0100; ch_bit[2] = seq[i]; end
            model_eval(); @(negedge clk);
            checks++; if (det_valid !== ((i == 5) || (i == 8))) begin errors++; $display("FAIL cfgpat det_valid c%0d: got %b exp %b", i, det_valid, ((i == 5) || (i == 8))); end
            checks++; if (ch_ready !== e_ready) begin errors++; $display("FAIL cfgpat ch_ready c%0d: got %b exp %b", i, ch_ready, e_ready); end
            if (e_dv) begin checks++; if (det_ch !== 2'd2) begin errors++; $display("FAIL cfgpat det_ch c%0d: got %0d exp 2", i, det_ch); end end
            model_commit(); @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        bit seq [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        apply_reset();
        det_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ch_valid = 4'b0001; ch_bit = '0; ch_bit[0] = seq[i];
            model_eval(); @(negedge clk);
            checks++; if (ch_ready !== 4'b0001) begin errors++; $display("FAIL bp stream ch_ready c%0d: got %b exp 0001", i, ch_ready); end
            model_commit(); @(posedge clk); #1;
        end
        ch_valid = 4'b0011; ch_bit = '0;
        for (int i = 0; i < 3; i++) begin
            model_eval(); @(negedge clk);
            checks++; if (ch_ready !== 4'b0000) begin errors++; $display("FAIL bp hold ch_ready c%0d: got %b exp 0000", i, ch_ready); end
            checks++; if (det_valid !== 1'b1) begin errors++; $display("FAIL bp hold det_valid c%0d: got %b exp 1", i, det_valid); end
            checks++; if (det_ch !== 2'd0) begin errors++; $display("FAIL bp hold det_ch c%0d: got %0d exp 0", i, det_ch); end
            model_commit(); @(posedge clk); #1;
        end
        det_ready = 1'b1;
        model_eval(); @(negedge clk);
        checks++; if (ch_ready !== 4'b0010) begin errors++; $display("FAIL bp release ch_ready: got %b exp 0010", ch_ready); end
        checks++; if (det_valid !== 1'b1) begin errors++; $display("FAIL bp release det_valid: got %b exp 1", det_valid); end
        model_commit(); @(posedge clk); #1;
        model_eval(); @(negedge clk);
        checks++; if (det_valid !== 1'b0) begin errors++; $display("FAIL bp consumed det_valid: got %b exp 0", det_valid); end
        checks++; if (ch_ready !== 4'b0001) begin errors++; $display("FAIL bp resume ch_ready: got %b exp 0001", ch_ready); end
        model_commit(); @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        bit seq [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            ch_valid = 4'b0001; ch_bit = '0; ch_bit[0] = seq[i];
            model_eval(); @(negedge clk); model_commit(); @(posedge clk); #1;
        end
        ch_bit = '0;
        #2 rst = 1'b1;
        #1;
        checks++; if (det_valid !== 1'b0) begin errors++; $display("FAIL midrst det_valid: got %b exp 0", det_valid); end
        checks++; if (ch_ready !== 4'b0000) begin errors++; $display("FAIL midrst ch_ready: got %b exp 0000", ch_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            ch_valid = 4'b0001; ch_bit = '0;
            model_eval(); @(negedge clk);
            checks++; if (det_valid !== 1'b0) begin errors++; $display("FAIL midrst after det_valid c%0d: got %b exp 0", i, det_valid); end
            checks++; if (ch_ready !== e_ready) begin errors++; $display("FAIL midrst after ch_ready c%0d: got %b exp %b", i, ch_ready, e_ready); end
            model_commit(); @(posedge clk); #1;
        end
    endtask

    task automatic test_len_limits();
        bit seq [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [MAXLEN-1:0] p;
        apply_reset();
        do_cfg(8'b0001_0010, 4'd0, 4'b1111);
        for (int i = 0; i < 7; i++) begin
            ch_valid = '0; ch_bit = '0;
            if (i < 5) begin ch_valid = 4'b0001; ch_bit[0] = seq[i]; end
            model_eval(); @(negedge clk);
            checks++; if (det_valid !== 1'b0) begin errors++; $display("FAIL len0 det_valid c%0d: got %b exp 0", i, det_valid); end
            model_commit(); @(posedge clk); #1;
        end
        p = MAXLEN'($urandom);
        do_cfg(p, 4'd12, 4'b1111);
        for (int i = 0; i < 10; i++) begin
            ch_valid = '0; ch_bit = '0;
            if (i < 8) begin ch_valid = 4'b0001; ch_bit[0] = p[MAXLEN-1-i]; end
            model_eval(); @(negedge clk);
            checks++; if (det_valid !== (i == 8)) begin errors++; $display("FAIL len12 det_valid c%0d: got %b exp %b", i, det_valid, (i == 8)); end
            checks++; if (det_valid !== e_dv) begin errors++; $display("FAIL len12 model det_valid c%0d: got %b exp %b", i, det_valid, e_dv); end
            model_commit(); @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            ch_valid  = NCH'($urandom);
            ch_bit    = NCH'($urandom);
            det_ready = ($urandom_range(0, 9) < 7);
            cfg_we    = ($urandom_range(0, 39) == 0);
            if (cfg_we) begin
                det_ready   = 1'b0;
                cfg_pattern = MAXLEN'($urandom);
                cfg_len     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                          : 4'($urandom_range(1, 4));
                cfg_ch_en   = NCH'($urandom) | NCH'(1);
            end
            model_eval(); @(negedge clk);
            checks++; if (ch_ready !== e_ready) begin errors++; $display("FAIL random ch_ready c%0d: got %b exp %b", i, ch_ready, e_ready); end
            checks++; if (det_valid !== e_dv) begin errors++; $display("FAIL random det_valid c%0d: got %b exp %b", i, det_valid, e_dv); end
            if (e_dv) begin checks++; if (det_ch !== CHW'(e_dch)) begin errors++; $display("FAIL random det_ch c%0d: got %0d exp %0d", i, det_ch, e_dch); end end
            model_commit(); @(posedge clk); #1;
            cfg_we = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_round_robin();
        test_cfg_pattern();
        test_backpressure();
        test_mid_reset();
        test_len_limits();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
